// File: rtl/keypad_matrix_emu_if.sv
// Press-command channel of the keypad matrix emulator.
// The command source drives the master side; the emulator is the slave.
interface keypad_matrix_emu_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_key;
  logic [15:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_matrix_emu.sv
// 5x4 keypad switch-matrix emulator: replays one commanded key press as
// press bounce, hold, release bounce and gap, and answers the scanner's column drive.
module keypad_matrix_emu #(
  parameter int BOUNCE_CYC  = 64,
  parameter int BOUNCE_STEP = 8,
  parameter int GAP_CYC     = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  keypad_matrix_emu_if.slave        cmd_if,
  input  logic [3:0]                key_col_i,
  output logic [4:0]                key_row_o,
  output logic                      busy_o,
  output logic                      contact_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int BW = (BOUNCE_CYC > 0) ? $clog2(BOUNCE_CYC + 1) : 1;
  localparam int SW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP + 1) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BW-1:0] BOUNCE_LAST = BW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
  localparam logic [SW-1:0] STEP_LAST   = SW'((BOUNCE_STEP > 0) ? BOUNCE_STEP - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST    = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [4:0]    NUM_KEYS    = 5'd20;

  typedef enum logic [2:0] {IDLE, PRESS_B, HOLD, REL_B, GAP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bounceCnt_q, bounceCnt_d;
  logic [SW-1:0] stepCnt_q, stepCnt_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [15:0]   holdCnt_q, holdCnt_d;
  logic [15:0]   holdLen_q, holdLen_d;
  logic [15:0]   holdLast;
  logic [4:0]    key_q, key_d;
  logic          contact_q, contact_d;
  logic [4:0]    keyRow_q, keyRow_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // A hold length of zero still gives one stable-pressed cycle.
  assign holdLast = (holdLen_q == 16'd0) ? 16'd0 : holdLen_q - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bounceCnt_q <= '0;
      stepCnt_q   <= '0;
      gapCnt_q    <= '0;
      holdCnt_q   <= '0;
      holdLen_q   <= '0;
      key_q       <= '0;
      contact_q   <= 1'b0;
      keyRow_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bounceCnt_q <= bounceCnt_d;
      stepCnt_q   <= stepCnt_d;
      gapCnt_q    <= gapCnt_d;
      holdCnt_q   <= holdCnt_d;
      holdLen_q   <= holdLen_d;
      key_q       <= key_d;
      contact_q   <= contact_d;
      keyRow_q    <= keyRow_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bounceCnt_d = bounceCnt_q;
    stepCnt_d   = stepCnt_q;
    gapCnt_d    = gapCnt_q;
    holdCnt_d   = holdCnt_q;
    holdLen_d   = holdLen_q;
    key_d       = key_q;
    contact_d   = contact_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (cmd_if.cmd_valid) begin
          if (cmd_if.cmd_key >= NUM_KEYS) begin
            err_d = 1'b1;
          end else begin
            key_d       = cmd_if.cmd_key;
            holdLen_d   = cmd_if.cmd_hold;
            bounceCnt_d = '0;
            stepCnt_d   = '0;
            holdCnt_d   = '0;
            contact_d   = 1'b1;
            state_d     = (BOUNCE_CYC > 0) ? PRESS_B : HOLD;
          end
        end
      end

      // Both bounce phases share the counters; only the starting level differs.
      PRESS_B, REL_B: begin
        if (bounceCnt_q == BOUNCE_LAST) begin
          if (state_q == PRESS_B) begin
            state_d   = HOLD;
            holdCnt_d = '0;
            contact_d = 1'b1;
          end else begin
            state_d   = GAP;
            gapCnt_d  = '0;
            contact_d = 1'b0;
          end
        end else begin
          bounceCnt_d = bounceCnt_q + 1'b1;
          if (stepCnt_q == STEP_LAST) begin
            stepCnt_d = '0;
            contact_d = ~contact_q;
          end else begin
            stepCnt_d = stepCnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        contact_d = 1'b1;
        if (holdCnt_q == holdLast) begin
          contact_d   = 1'b0;
          bounceCnt_d = '0;
          stepCnt_d   = '0;
          gapCnt_d    = '0;
          state_d     = (BOUNCE_CYC > 0) ? REL_B : GAP;
        end else begin
          holdCnt_d = holdCnt_q + 16'd1;
        end
      end

      GAP: begin
        contact_d = 1'b0;
        if (gapCnt_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase

    // Row sense is built from the next contact level so it tracks key_col with one cycle of latency.
    keyRow_d = '0;
    if (contact_d && key_col_i[key_d[1:0]]) begin
      keyRow_d = 5'(5'b00001 << key_d[4:2]);
    end
  end

  assign cmd_if.cmd_ready = (state_q == IDLE);
  assign key_row_o        = keyRow_q;
  assign busy_o           = (state_q != IDLE);
  assign contact_o        = contact_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Randomized bench for keypad_matrix_emu: a clean-edge instance and a bouncing instance
// are compared every cycle against a queue-based model of the press sequence.
module tb_keypad_matrix_emu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pBc[2]   = '{0, 16};
  int pStep[2] = '{1, 4};
  int pGap[2]  = '{4, 8};

  logic        valid[2];
  logic [4:0]  key[2];
  logic [15:0] hold[2];
  logic [3:0]  col[2];

  logic [4:0]  rowO[2];
  logic        busyO[2];
  logic        contactO[2];
  logic        doneO[2];
  logic        errO[2];
  logic        readyO[2];

  int checks = 0;
  int errors = 0;

  keypad_matrix_emu_if ifA ();
  keypad_matrix_emu_if ifB ();

  assign ifA.cmd_valid = valid[0];
  assign ifA.cmd_key   = key[0];
  assign ifA.cmd_hold  = hold[0];
  assign ifB.cmd_valid = valid[1];
  assign ifB.cmd_key   = key[1];
  assign ifB.cmd_hold  = hold[1];
  assign readyO[0]     = ifA.cmd_ready;
  assign readyO[1]     = ifB.cmd_ready;

  keypad_matrix_emu #(.BOUNCE_CYC(0), .BOUNCE_STEP(1), .GAP_CYC(4)) dutClean (
    .clk       (clk),
    .rst       (rst),
    .cmd_if    (ifA.slave),
    .key_col_i (col[0]),
    .key_row_o (rowO[0]),
    .busy_o    (busyO[0]),
    .contact_o (contactO[0]),
    .done_o    (doneO[0]),
    .err_o     (errO[0])
  );

  keypad_matrix_emu #(.BOUNCE_CYC(16), .BOUNCE_STEP(4), .GAP_CYC(8)) dutBounce (
    .clk       (clk),
    .rst       (rst),
    .cmd_if    (ifB.slave),
    .key_col_i (col[1]),
    .key_row_o (rowO[1]),
    .busy_o    (busyO[1]),
    .contact_o (contactO[1]),
    .done_o    (doneO[1]),
    .err_o     (errO[1])
  );

  // Model: each accepted press becomes a list of per-cycle contact levels.
  int          q0[$];
  int          q1[$];
  bit          expContact[2];
  bit          expBusy[2];
  bit          expDone[2];
  bit          expErr[2];
  logic [4:0]  expRow[2];
  int          mKey[2];

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input int d);
    checkOutput($sformatf("row%0d", d), 16'(rowO[d]), 16'(expRow[d]));
    checkOutput($sformatf("contact%0d", d), 16'(contactO[d]), 16'(expContact[d]));
    checkOutput($sformatf("busy%0d", d), 16'(busyO[d]), 16'(expBusy[d]));
    checkOutput($sformatf("ready%0d", d), 16'(readyO[d]), 16'(!expBusy[d]));
    checkOutput($sformatf("done%0d", d), 16'(doneO[d]), 16'(expDone[d]));
    checkOutput($sformatf("err%0d", d), 16'(errO[d]), 16'(expErr[d]));
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      expContact[d] = 1'b0;
      expBusy[d]    = 1'b0;
      expDone[d]    = 1'b0;
      expErr[d]     = 1'b0;
      expRow[d]     = '0;
      mKey[d]       = 0;
    end
  endtask

  task automatic buildPress(input int d, output int seq[$]);
    int hl;
    int gl;
    seq.delete();
    hl = (hold[d] == 16'd0) ? 1 : int'(hold[d]);
    gl = (pGap[d] == 0) ? 1 : pGap[d];
    for (int i = 0; i < pBc[d]; i++) seq.push_back(((i / pStep[d]) % 2 == 0) ? 1 : 0);
    for (int i = 0; i < hl; i++) seq.push_back(1);
    for (int i = 0; i < pBc[d]; i++) seq.push_back(((i / pStep[d]) % 2 == 1) ? 1 : 0);
    for (int i = 0; i < gl; i++) seq.push_back(0);
  endtask

  task automatic modelStep(input int d);
    int seq[$];
    int c;
    expDone[d] = 1'b0;
    expErr[d]  = 1'b0;
    if ((d == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
      c = (d == 0) ? q0.pop_front() : q1.pop_front();
      expContact[d] = (c != 0);
      expBusy[d]    = 1'b1;
    end else if (expBusy[d]) begin
      expContact[d] = 1'b0;
      expBusy[d]    = 1'b0;
      expDone[d]    = 1'b1;
    end else begin
      expContact[d] = 1'b0;
      if (valid[d]) begin
        if (key[d] >= 5'd20) begin
          expErr[d] = 1'b1;
        end else begin
          mKey[d] = int'(key[d]);
          buildPress(d, seq);
          c = seq.pop_front();
          if (d == 0) q0 = seq; else q1 = seq;
          expContact[d] = (c != 0);
          expBusy[d]    = 1'b1;
        end
      end
    end
    expRow[d] = (expContact[d] && col[d][mKey[d] % 4]) ? 5'(5'd1 << (mKey[d] / 4)) : 5'd0;
  endtask

  task automatic applyStimulus(input int mode, input int n);
    int r;
    for (int d = 0; d < 2; d++) begin
      case (mode)
        1: begin
          valid[d] = (n == 0);
          key[d]   = 5'd0;
          hold[d]  = 16'd100;
          col[d]   = 4'b0001;
        end
        2: begin
          valid[d] = (d == 0) && (n == 0);
          key[d]   = 5'd19;
          hold[d]  = 16'd12;
          col[d]   = (d == 0) ? 4'(4'b0001 << (n % 4)) : 4'b0000;
        end
        3: begin
          valid[d] = (n == 0);
          key[d]   = 5'd20;
          hold[d]  = 16'd5;
          col[d]   = 4'b1111;
        end
        default: begin
          valid[d] = ($urandom_range(0, 3) != 0);
          key[d]   = 5'($urandom_range(0, 21));
          hold[d]  = 16'($urandom_range(0, 12));
          r = $urandom_range(0, 3);
          if (r == 0)      col[d] = 4'b0000;
          else if (r == 3) col[d] = 4'($urandom_range(0, 15));
          else             col[d] = 4'(4'b0001 << $urandom_range(0, 3));
        end
      endcase
    end
  endtask

  task automatic runCycles(input int mode, input int count);
    for (int n = 0; n < count; n++) begin
      applyStimulus(mode, n);
      modelStep(0);
      modelStep(1);
      @(negedge clk);
      checkAll(0);
      checkAll(1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0;
      key[d]   = '0;
      hold[d]  = '0;
      col[d]   = '0;
    end
    modelReset();
    #12;
    @(negedge clk);
    rst = 1'b0;
    checkAll(0);
    checkAll(1);

    $display("[TB] reset during hold");
    runCycles(1, 30);
    checkOutput("t1RowBefore0", 16'(rowO[0]), 16'd1);
    checkOutput("t1RowBefore1", 16'(rowO[1]), 16'd1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("t1Row%0d", d), 16'(rowO[d]), 16'd0);
      checkOutput($sformatf("t1Busy%0d", d), 16'(busyO[d]), 16'd0);
      checkOutput($sformatf("t1Contact%0d", d), 16'(contactO[d]), 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkAll(0);
    checkAll(1);

    $display("[TB] column walk on key 19");
    runCycles(2, 24);

    $display("[TB] invalid key");
    runCycles(3, 4);

    $display("[TB] random presses");
    runCycles(0, 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
